// File: rtl/rtl_wb_arbiter.sv
// Write-back arbiter: merges a single-cycle ALU result stream and a FIFO-buffered
// LSU/MUL stream into one registered register-file write port.
module rtl_wb_arbiter #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int NREG       = 32,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [AW-1:0]   alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            lsu_valid,
  output logic            lsu_ready,
  input  logic [AW-1:0]   lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            we,
  output logic [AW-1:0]   waddr,
  output logic [XLEN-1:0] wdata,
  output logic [NREG-1:0] pend_mask
);
  localparam int LW = $clog2(DEPTH);
  localparam int PW = LW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [AW-1:0]   fifo_rd   [DEPTH];
  logic [XLEN-1:0] fifo_data [DEPTH];
  logic [PW-1:0]   wptr, rptr, count;
  logic [SW-1:0]   starve_cnt;
  logic            empty, full, starve;
  logic            alu_fire, lsu_fire, pop, bypass, push;
  logic            sel_valid;
  logic [AW-1:0]   sel_rd;
  logic [XLEN-1:0] sel_data;
  logic [LW-1:0]   slot;

  assign empty  = (wptr == rptr);
  assign full   = (wptr[PW-1] != rptr[PW-1]) && (wptr[LW-1:0] == rptr[LW-1:0]);
  assign count  = wptr - rptr;
  assign starve = (starve_cnt == SW'(STARVE_MAX)) && !empty;

  // Handshake: a source transfers on a posedge where valid && ready; it holds
  // rd/data stable until then. Readies are low throughout reset.
  assign alu_ready = rst_n && !starve;
  assign lsu_ready = rst_n && !full;

  assign alu_fire = alu_valid && alu_ready;
  assign lsu_fire = lsu_valid && lsu_ready;
  // When starving, alu_fire is already 0, so the head pops through the same path.
  assign pop      = !empty && !alu_fire;
  assign bypass   = lsu_fire && empty && !alu_fire;
  assign push     = lsu_fire && !bypass;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = alu_rd;
      sel_data  = alu_data;
    end else if (pop) begin
      sel_valid = 1'b1;
      sel_rd    = fifo_rd[rptr[LW-1:0]];
      sel_data  = fifo_data[rptr[LW-1:0]];
    end else if (bypass) begin
      sel_valid = 1'b1;
      sel_rd    = lsu_rd;
      sel_data  = lsu_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wptr[LW-1:0]]   <= lsu_rd;
      fifo_data[wptr[LW-1:0]] <= lsu_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      starve_cnt <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (empty || pop)
        starve_cnt <= '0;
      else if (alu_fire && (starve_cnt != SW'(STARVE_MAX)))
        starve_cnt <= starve_cnt + 1'b1;
      // x0 is hardwired: address/data still track, but the write is suppressed.
      we <= sel_valid && (sel_rd != '0);
      if (sel_valid) begin
        waddr <= sel_rd;
        wdata <= sel_data;
      end
    end
  end

  always_comb begin
    pend_mask = '0;
    slot      = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (PW'(k) < count) begin
        slot = rptr[LW-1:0] + LW'(k);
        pend_mask[fifo_rd[slot]] = 1'b1;
      end
    end
    if (we) pend_mask[waddr] = 1'b1;
    pend_mask[0] = 1'b0;
  end
endmodule

// File: tb/tb_rtl_wb_arbiter.sv
// Directed bench for rtl_wb_arbiter: reset, ALU stream, merge, starvation,
// FIFO fill/wrap, x0 writes and mid-operation reset.
module tb_rtl_wb_arbiter;
  logic        clk, rst_n;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, waddr;
  logic [31:0] alu_data, lsu_data, wdata, pend_mask;
  logic        we;

  int tests = 0;
  int fails = 0;
  logic [36:0] exp_q[$];

  rtl_wb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .we(we), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; alu_valid = 1'b0; lsu_valid = 1'b0;
    alu_rd = '0; alu_data = '0; lsu_rd = '0; lsu_data = '0;
    #3;
    tests++;
    if ({we, waddr, wdata, pend_mask} !== 70'd0) begin
      fails++; $display("FAIL reset_out we=%0b waddr=%0d wdata=%h pend=%h exp all 0", we, waddr, wdata, pend_mask);
    end
    tests++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin
      fails++; $display("FAIL reset_ready got %b exp 00", {alu_ready, lsu_ready});
    end
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    tests++;
    if ({alu_ready, lsu_ready} !== 2'b11) begin
      fails++; $display("FAIL release_ready got %b exp 11", {alu_ready, lsu_ready});
    end
    step();
  endtask

  task automatic test_alu_stream();
    for (int r = 1; r <= 5; r++) begin
      alu_valid = 1'b1; alu_rd = 5'(r); alu_data = 32'(r * 16);
      #2;
      tests++;
      if (alu_ready !== 1'b1) begin
        fails++; $display("FAIL alu_stream_ready rd=%0d got %b exp 1", r, alu_ready);
      end
      step();
      tests++;
      if (we !== 1'b1 || waddr !== 5'(r) || wdata !== 32'(r * 16)) begin
        fails++; $display("FAIL alu_stream_write got we=%b x%0d=%h exp we=1 x%0d=%h", we, waddr, wdata, r, r * 16);
      end
      tests++;
      if (pend_mask !== (32'd1 << r)) begin
        fails++; $display("FAIL alu_stream_pend got %h exp %h", pend_mask, 32'd1 << r);
      end
    end
    alu_valid = 1'b0;
    step();
    tests++;
    if (we !== 1'b0 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL alu_stream_idle got we=%b pend=%h exp 0/0", we, pend_mask);
    end
  endtask

  task automatic test_merge();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAA;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'hBB;
    #2;
    tests++;
    if ({alu_ready, lsu_ready} !== 2'b11) begin
      fails++; $display("FAIL merge_ready got %b exp 11", {alu_ready, lsu_ready});
    end
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tests++;
    if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'hAA || pend_mask !== 32'h18) begin
      fails++; $display("FAIL merge_c1 got we=%b x%0d=%h pend=%h exp 1 x3=aa pend=18", we, waddr, wdata, pend_mask);
    end
    step();
    tests++;
    if (we !== 1'b1 || waddr !== 5'd4 || wdata !== 32'hBB || pend_mask !== 32'h10) begin
      fails++; $display("FAIL merge_c2 got we=%b x%0d=%h pend=%h exp 1 x4=bb pend=10", we, waddr, wdata, pend_mask);
    end
    step();
    tests++;
    if (we !== 1'b0 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL merge_idle got we=%b pend=%h exp 0/0", we, pend_mask);
    end
  endtask

  task automatic test_starve();
    bit exp_rdy[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 0, 1};
    int n = 0;
    logic [36:0] e;
    exp_q.delete();
    for (int c = 0; c < 10; c++) begin
      alu_valid = 1'b1; alu_rd = 5'((n % 7) + 1); alu_data = 32'hA0 + 32'(n);
      lsu_valid = (c < 2); lsu_rd = 5'(10 + c); lsu_data = 32'h100 + 32'(c);
      #2;
      tests++;
      if (alu_ready !== exp_rdy[c]) begin
        fails++; $display("FAIL starve_alu_ready c=%0d got %b exp %b", c, alu_ready, exp_rdy[c]);
      end
      if (c < 2) begin
        tests++;
        if (lsu_ready !== 1'b1) begin
          fails++; $display("FAIL starve_lsu_ready c=%0d got %b exp 1", c, lsu_ready);
        end
        exp_q.push_back({lsu_rd, lsu_data});
      end
      step();
      if (exp_rdy[c]) begin
        e = {5'((n % 7) + 1), 32'hA0 + 32'(n)};
        n++;
      end else begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'd0;
      end
      tests++;
      if (we !== 1'b1 || {waddr, wdata} !== e) begin
        fails++; $display("FAIL starve_write c=%0d got we=%b x%0d=%h exp we=1 x%0d=%h", c, we, waddr, wdata, e[36:32], e[31:0]);
      end
    end
    alu_valid = 1'b0; lsu_valid = 1'b0;
    step();
    tests++;
    if (we !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL starve_drain got we=%b left=%0d exp 0/0", we, exp_q.size());
    end
  endtask

  task automatic test_fill();
    bit rdy_e[6]    = '{1, 1, 1, 1, 0, 1};
    logic [36:0] e, cur;
    logic [31:0] m;
    int ai, li;
    for (int f = 0; f < 3; f++) begin
      ai = 0; li = 0;
      exp_q.delete();
      for (int c = 0; c < 6; c++) begin
        alu_valid = 1'b1; alu_rd = 5'(20 + ai); alu_data = 32'hC00 + 32'(ai + f * 16);
        lsu_valid = 1'b1; lsu_rd = 5'(8 + li); lsu_data = 32'h500 + 32'(li + f * 16);
        cur = {alu_rd, alu_data};
        #2;
        tests++;
        if (alu_ready !== rdy_e[c] || lsu_ready !== rdy_e[c]) begin
          fails++; $display("FAIL fill_ready f=%0d c=%0d got alu=%b lsu=%b exp %b", f, c, alu_ready, lsu_ready, rdy_e[c]);
        end
        if (rdy_e[c]) begin
          exp_q.push_back({lsu_rd, lsu_data});
          li++;
        end
        step();
        if (rdy_e[c]) begin
          e = cur; ai++;
        end else begin
          e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'd0;
        end
        tests++;
        if (we !== 1'b1 || {waddr, wdata} !== e) begin
          fails++; $display("FAIL fill_write f=%0d c=%0d got x%0d=%h exp x%0d=%h", f, c, waddr, wdata, e[36:32], e[31:0]);
        end
      end
      m = 32'd1 << e[36:32];
      foreach (exp_q[i]) m = m | (32'd1 << exp_q[i][36:32]);
      tests++;
      if (pend_mask !== m) begin
        fails++; $display("FAIL fill_pend f=%0d got %h exp %h", f, pend_mask, m);
      end
      alu_valid = 1'b0; lsu_valid = 1'b0;
      for (int d = 0; d < 4; d++) begin
        step();
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 37'd0;
        tests++;
        if (we !== 1'b1 || {waddr, wdata} !== e) begin
          fails++; $display("FAIL fill_drain f=%0d d=%0d got we=%b x%0d=%h exp x%0d=%h", f, d, we, waddr, wdata, e[36:32], e[31:0]);
        end
      end
      step();
      tests++;
      if (we !== 1'b0 || pend_mask !== 32'd0) begin
        fails++; $display("FAIL fill_empty f=%0d got we=%b pend=%h exp 0/0", f, we, pend_mask);
      end
    end
  endtask

  task automatic test_rd0();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h55;
    step();
    tests++;
    if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h55 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL rd0_alu got we=%b x%0d=%h pend=%h exp 0 x0=55 pend=0", we, waddr, wdata, pend_mask);
    end
    alu_data = 32'h66;
    lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'h77;
    step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    tests++;
    if (we !== 1'b0 || wdata !== 32'h66 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL rd0_both got we=%b wdata=%h pend=%h exp 0/66/0", we, wdata, pend_mask);
    end
    step();
    tests++;
    if (we !== 1'b0 || wdata !== 32'h77 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL rd0_pop got we=%b wdata=%h pend=%h exp 0/77/0", we, wdata, pend_mask);
    end
    step();
    tests++;
    if (we !== 1'b0 || wdata !== 32'h77) begin
      fails++; $display("FAIL rd0_idle got we=%b wdata=%h exp 0/77", we, wdata);
    end
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 3; c++) begin
      alu_valid = 1'b1; alu_rd = 5'(c + 1); alu_data = 32'(c);
      lsu_valid = 1'b1; lsu_rd = 5'(12 + c); lsu_data = 32'(100 + c);
      step();
    end
    tests++;
    if (we !== 1'b1 || waddr !== 5'd3 || pend_mask !== 32'h7008) begin
      fails++; $display("FAIL rstmid_pre got we=%b x%0d pend=%h exp 1 x3 pend=7008", we, waddr, pend_mask);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'd0 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL rstmid_out got we=%b x%0d=%h pend=%h exp all 0", we, waddr, wdata, pend_mask);
    end
    tests++;
    if ({alu_ready, lsu_ready} !== 2'b00) begin
      fails++; $display("FAIL rstmid_ready got %b exp 00", {alu_ready, lsu_ready});
    end
    repeat (2) step();
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++;
    if ({alu_ready, lsu_ready} !== 2'b11) begin
      fails++; $display("FAIL rstmid_release got %b exp 11", {alu_ready, lsu_ready});
    end
    step();
    tests++;
    if (we !== 1'b0 || pend_mask !== 32'd0) begin
      fails++; $display("FAIL rstmid_empty got we=%b pend=%h exp 0/0", we, pend_mask);
    end
  endtask

  initial begin
    test_reset();
    test_alu_stream();
    test_merge();
    test_starve();
    test_fill();
    test_rd0();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
